// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// request capture record, LFSR geometry and the default base address.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request fields kept from the acceptance cycle until the access is made.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        is_write;
    logic        err;
  } req_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> state bits 7,5,4,3.
  localparam int             LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bus between the EXU load/store unit (master) and the
// data-memory responder (slave).
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we_mask;
  logic        mem_wen;
  logic        mem_ren;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_is_write;

  modport master (
    output req_valid, mem_addr, mem_wdata, mem_we_mask, mem_wen, mem_ren, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
  );

  modport slave (
    input  req_valid, mem_addr, mem_wdata, mem_we_mask, mem_wen, mem_ren, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
  );
endinterface

// File: rtl/dmem_lfsr.sv
// 8-bit Fibonacci LFSR that steps every cycle; its two low bits add a
// pseudo-random 0..3 cycles to the responder latency. Only instantiated when
// DMEM_RAND_DELAY_EN is defined.
module dmem_lfsr
  import dmem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] rnd_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR state register, reseeded on reset.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[1:0];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised SRAM behind a valid/ready request
// and response handshake, one request at a time, programmable latency.
// Optional feature: define DMEM_RAND_DELAY_EN to add 0..3 pseudo-random
// extra BUSY cycles per access (LFSR-driven).
module dmem_resp
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  dmem_resp_if.slave bus
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int          CNT_W      = $clog2(LATENCY + 3) + 1;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_load;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_is_write_q;

  req_t              req_q, req_d;
  logic [IDX_W-1:0]  idx_q;

  logic              accept;
  logic              access;
  logic              mem_we;

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic [31:0]       mem_q [DEPTH_WORDS];

  // Address decode: unsigned wrap makes addresses below BASE_ADDR out of range.
  assign offset   = bus.mem_addr - BASE_ADDR;
  assign in_range = offset < SPAN_BYTES;
  assign idx      = offset[IDX_W+1:2];

`ifdef DMEM_RAND_DELAY_EN
  logic [1:0] lfsr_rnd;

  dmem_lfsr u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rnd_o (lfsr_rnd)
  );

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_rnd);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // Classify the incoming request; both or neither of wen/ren is an error.
  always_comb begin
    req_d.wdata    = bus.mem_wdata;
    req_d.mask     = bus.mem_we_mask;
    req_d.is_write = bus.mem_wen;
    req_d.err      = !in_range || (bus.mem_wen == bus.mem_ren);
  end

  // Next-state logic: accept in IDLE, count down in BUSY, hold in RESP.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          accept  = 1'b1;
          cnt_d   = cnt_load;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, handshake flags and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_is_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      if (access) begin
        rsp_err_q      <= req_q.err;
        rsp_is_write_q <= req_q.is_write;
        rsp_rdata_q    <= (!req_q.err && !req_q.is_write) ? mem_q[idx_q] : '0;
      end
    end
  end

  // Capture the request at acceptance; inputs may change freely afterwards.
  // Only consumed after an acceptance, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_q <= req_d;
      idx_q <= idx;
    end
  end

  assign mem_we = access && !req_q.err && req_q.is_write;

  // Byte-masked write into the array; a reset on the access edge drops it.
  // NOTE: the array has no reset so it maps onto plain RAM; contents are
  // undefined until written.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int k = 0; k < 4; k++) begin
        if (req_q.mask[k]) mem_q[idx_q][8*k +: 8] <= req_q.wdata[8*k +: 8];
      end
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_is_write = rsp_is_write_q;

endmodule
